fifo_buffer_fwft: RTL and testbench

//  Parametrised synchronous FIFO, successor to the distributed-RAM queue: register-array storage,

---
 rtl/fifo_buffer_fwft_if.sv | 32 +++
 rtl/fifo_buffer_fwft.sv | 116 +++++++++++
 tb/tb_fifo_buffer_fwft.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_buffer_fwft_if.sv
// Producer/consumer bundle for fifo_buffer_fwft; slave is the FIFO side, master is the user side.
interface fifo_buffer_fwft_if #(
   parameter int unsigned LOG2_DEPTH = 2,
   parameter int unsigned DATA_WIDTH = 16
);
   logic                  clear_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  wvalid_i;
   logic                  wready_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  rvalid_o;
   logic                  rready_i;
   logic [LOG2_DEPTH:0]   count_o;
   logic                  full_o;
   logic                  empty_o;
   logic                  almost_full_o;
   logic                  almost_empty_o;
   logic                  overflow_o;
   logic                  underflow_o;

   modport slave (
      input  clear_i, wdata_i, wvalid_i, rready_i,
      output wready_o, rdata_o, rvalid_o, count_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o
   );

   modport master (
      output clear_i, wdata_i, wvalid_i, rready_i,
      input  wready_o, rdata_o, rvalid_o, count_o, full_o, empty_o,
             almost_full_o, almost_empty_o, overflow_o, underflow_o
   );
endinterface

// File: rtl/fifo_buffer_fwft.sv
// Synchronous first-word-fall-through FIFO with occupancy count, almost thresholds and flush.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module fifo_buffer_fwft #(
   parameter int unsigned LOG2_DEPTH       = 2,
   parameter int unsigned DATA_WIDTH       = 16,
   parameter int unsigned ALMOST_FULL_LVL  = (1 << LOG2_DEPTH) - 1,
   parameter int unsigned ALMOST_EMPTY_LVL = 1
) (
   input  logic               clk,
   input  logic               reset,
   fifo_buffer_fwft_if.slave  bus
);

   localparam int unsigned AW    = LOG2_DEPTH;
   localparam int unsigned PW    = LOG2_DEPTH + 1;
   localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

   localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LVL);
   localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LVL);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] count_q, count_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   // Wrap bit distinguishes full from empty when the index bits coincide.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   assign push = bus.wvalid_i & ~full;
   assign pop  = bus.rready_i & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; writes are dropped during reset and flush.
   always_ff @(posedge clk) begin
      if (!reset && !bus.clear_i && push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= bus.wdata_i;
      end
   end

   assign bus.rdata_o        = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.rvalid_o       = ~empty;
   assign bus.wready_o       = ~full;
   assign bus.full_o         = full;
   assign bus.empty_o        = empty;
   assign bus.count_o        = count_q;
   assign bus.almost_full_o  = (count_q >= AF_LVL);
   assign bus.almost_empty_o = (count_q <= AE_LVL);

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   always_comb begin
      overflow_d  = overflow_q  | (bus.wvalid_i & full);
      underflow_d = underflow_q | (bus.rready_i & empty);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.overflow_o  = overflow_q;
   assign bus.underflow_o = underflow_q;
`else
   assign bus.overflow_o  = 1'b0;
   assign bus.underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_buffer_fwft.sv
// Directed plus randomized bench for fifo_buffer_fwft against a queue-based reference model.
module tb_fifo_buffer_fwft;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

   logic [15:0] q [$];
   logic        ovf_m = 1'b0;
   logic        unf_m = 1'b0;

   fifo_buffer_fwft_if #(.LOG2_DEPTH(2), .DATA_WIDTH(16)) bus ();

   fifo_buffer_fwft #(.LOG2_DEPTH(2), .DATA_WIDTH(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int n;
      n = q.size();
      check({tag, ".count"},  32'(bus.count_o),        32'(n));
      check({tag, ".empty"},  32'(bus.empty_o),        32'(n == 0));
      check({tag, ".full"},   32'(bus.full_o),         32'(n == 4));
      check({tag, ".rvalid"}, 32'(bus.rvalid_o),       32'(n != 0));
      check({tag, ".wready"}, 32'(bus.wready_o),       32'(n != 4));
      check({tag, ".afull"},  32'(bus.almost_full_o),  32'(n >= 3));
      check({tag, ".aempty"}, 32'(bus.almost_empty_o), 32'(n <= 1));
      check({tag, ".ovf"},    32'(bus.overflow_o),     32'(ovf_m));
      check({tag, ".unf"},    32'(bus.underflow_o),    32'(unf_m));
      if (n != 0) begin
         check({tag, ".rdata"}, 32'(bus.rdata_o), 32'(q[0]));
      end
   endtask

   // One clock with the given inputs; the model advances from the pre-edge occupancy.
   task automatic step(input string tag, input logic rst, input logic clr,
                       input logic wv, input logic [15:0] wd, input logic rr);
      int n;
      reset        = rst;
      bus.clear_i  = clr;
      bus.wvalid_i = wv;
      bus.wdata_i  = wd;
      bus.rready_i = rr;
      n = q.size();
      if (rst) begin
         q.delete();
         ovf_m = 1'b0;
         unf_m = 1'b0;
      end else begin
`ifdef FIFO_ERR_FLAGS_EN
         if (wv && n == 4) ovf_m = 1'b1;
         if (rr && n == 0) unf_m = 1'b1;
`endif
         if (clr) begin
            q.delete();
         end else begin
            if (rr && n != 0) void'(q.pop_front());
            if (wv && n != 4) q.push_back(wd);
         end
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      reset        = 1'b1;
      bus.clear_i  = 1'b0;
      bus.wvalid_i = 1'b0;
      bus.wdata_i  = '0;
      bus.rready_i = 1'b0;

      // 1: reset for two cycles
      step("rst0", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
      step("rst1", 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);

      // 2: fill, then refused fifth push
      for (int i = 1; i <= 4; i++) step("fill", 1'b0, 1'b0, 1'b1, 16'hA000 + 16'(i), 1'b0);
      step("push_full", 1'b0, 1'b0, 1'b1, 16'hA005, 1'b0);
      step("idle_full", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

      // 3: drain in order, then a pop while empty
      for (int i = 0; i < 4; i++) step("drain", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      step("pop_empty", 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      step("idle_empty", 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

      // 5: first-word fall-through latency from empty
      check_all("pre_ff");
      step("ff", 1'b0, 1'b0, 1'b1, 16'h00FF, 1'b0);

      // 4: steady push+pop at occupancy 2 across several pointer wraps
      step("to2", 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0);
      for (int i = 0; i < 20; i++) step("stream", 1'b0, 1'b0, 1'b1, 16'(i), 1'b1);

      // 6: flush with concurrent push, then reset mid-stream
      step("to3", 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0);
      step("clr", 1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0);
      step("post_clr", 1'b0, 1'b0, 1'b1, 16'h0C01, 1'b0);
      step("post_clr2", 1'b0, 1'b0, 1'b1, 16'h0C02, 1'b0);
      step("mid_rst", 1'b1, 1'b0, 1'b1, 16'hDEAD, 1'b1);
      step("after_rst", 1'b0, 1'b0, 1'b1, 16'h0E00, 1'b0);

      // Randomized traffic alternating between fill-heavy and drain-heavy phases
      for (int i = 0; i < 600; i++) begin
         int  bias;
         logic wv, rr, clr, rst;
         bias = ((i / 50) % 2 == 0) ? 75 : 30;
         wv   = ($urandom_range(0, 99) < bias);
         rr   = ($urandom_range(0, 99) < (100 - bias));
         clr  = ($urandom_range(0, 99) < 3);
         rst  = ($urandom_range(0, 199) < 1);
         step("rand", rst, clr, wv, 16'($urandom), rr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
